// File: rtl/cache_axi_lines.sv
// Direct-mapped read cache with an AXI4 read master that refills whole lines as INCR bursts.
// Optional CACHE_AXI_FLUSH_EN adds a FLUSH input that invalidates every line.
module cache_axi_lines #(
  parameter int LINES      = 64,
  parameter int LINE_WORDS = 8
) (
  input  logic        CLK,
  input  logic        RSTN,
`ifdef CACHE_AXI_FLUSH_EN
  input  logic        FLUSH,
`endif
  input  logic [31:0] HIT_CHECK,
  output logic        HIT_CHECK_RESULT,
  input  logic        RDEN,
  input  logic [31:0] RADDR,
  output logic        RVALID,
  output logic [31:0] RDATA,
  output logic        ERR,
  output logic [31:0] M_AXI_ARADDR,
  output logic [7:0]  M_AXI_ARLEN,
  output logic [2:0]  M_AXI_ARSIZE,
  output logic [1:0]  M_AXI_ARBURST,
  output logic        M_AXI_ARVALID,
  input  logic        M_AXI_ARREADY,
  input  logic [31:0] M_AXI_RDATA,
  input  logic [1:0]  M_AXI_RRESP,
  input  logic        M_AXI_RLAST,
  input  logic        M_AXI_RVALID,
  output logic        M_AXI_RREADY,
  output logic [31:0] M_AXI_AWADDR,
  output logic [7:0]  M_AXI_AWLEN,
  output logic [2:0]  M_AXI_AWSIZE,
  output logic [1:0]  M_AXI_AWBURST,
  output logic        M_AXI_AWVALID,
  input  logic        M_AXI_AWREADY,
  output logic [31:0] M_AXI_WDATA,
  output logic [3:0]  M_AXI_WSTRB,
  output logic        M_AXI_WLAST,
  output logic        M_AXI_WVALID,
  input  logic        M_AXI_WREADY,
  input  logic [1:0]  M_AXI_BRESP,
  input  logic        M_AXI_BVALID,
  output logic        M_AXI_BREADY
);
  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 30 - OFF_W - IDX_W;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_READ = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [LINES-1:0] valid_q, valid_d;
  logic [31:0]      araddr_q, araddr_d;
  logic             arvalid_q, arvalid_d;
  logic [OFF_W-1:0] beat_q, beat_d;
  logic             berr_q, berr_d;
  logic [IDX_W-1:0] idx_l_q, idx_l_d;
  logic [TAG_W-1:0] tag_l_q, tag_l_d;
  logic             beat_we, tag_we, rvalid_o, err_o, flush_now, beat_bad;

  logic [TAG_W-1:0] tag_mem  [LINES];
  logic [31:0]      data_mem [LINES*LINE_WORDS];

  logic [OFF_W-1:0] r_off;
  logic [IDX_W-1:0] r_idx, h_idx;
  logic [TAG_W-1:0] r_tag, h_tag;
  logic             r_hit, h_hit;

  assign r_off = RADDR[OFF_W+1:2];
  assign r_idx = RADDR[IDX_W+OFF_W+1:OFF_W+2];
  assign r_tag = RADDR[31:IDX_W+OFF_W+2];
  assign h_idx = HIT_CHECK[IDX_W+OFF_W+1:OFF_W+2];
  assign h_tag = HIT_CHECK[31:IDX_W+OFF_W+2];
  assign r_hit = valid_q[r_idx] && (tag_mem[r_idx] == r_tag);
  assign h_hit = valid_q[h_idx] && (tag_mem[h_idx] == h_tag);

`ifdef CACHE_AXI_FLUSH_EN
  logic flush_pend_q, flush_pend_d;
`endif

  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    araddr_d  = araddr_q;
    arvalid_d = arvalid_q;
    beat_d    = beat_q;
    berr_d    = berr_q;
    idx_l_d   = idx_l_q;
    tag_l_d   = tag_l_q;
    beat_we   = 1'b0;
    tag_we    = 1'b0;
    rvalid_o  = 1'b0;
    err_o     = 1'b0;
    flush_now = 1'b0;
    beat_bad  = M_AXI_RRESP != 2'b00;
`ifdef CACHE_AXI_FLUSH_EN
    flush_pend_d = flush_pend_q;
    if (state_q == ST_IDLE) flush_now = FLUSH || flush_pend_q;
    else if (FLUSH)         flush_pend_d = 1'b1;
`endif
    case (state_q)
      ST_IDLE: begin
        if (flush_now) begin
          valid_d = '0;
`ifdef CACHE_AXI_FLUSH_EN
          flush_pend_d = 1'b0;
`endif
        end else if (RDEN && r_hit) begin
          rvalid_o = 1'b1;
        end else if (RDEN) begin
          // Invalidate before refilling so a half-written line can never hit.
          state_d        = ST_ADDR;
          araddr_d       = {r_tag, r_idx, {(OFF_W+2){1'b0}}};
          arvalid_d      = 1'b1;
          valid_d[r_idx] = 1'b0;
          idx_l_d        = r_idx;
          tag_l_d        = r_tag;
          beat_d         = '0;
          berr_d         = 1'b0;
        end
      end
      ST_ADDR: begin
        if (M_AXI_ARREADY) begin
          arvalid_d = 1'b0;
          state_d   = ST_READ;
        end
      end
      ST_READ: begin
        if (M_AXI_RVALID) begin
          beat_we = 1'b1;
          beat_d  = beat_q + 1'b1;
          if (beat_bad) berr_d = 1'b1;
          if (M_AXI_RLAST) begin
            state_d          = ST_IDLE;
            valid_d[idx_l_q] = !(berr_q || beat_bad);
            tag_we           = !(berr_q || beat_bad);
            err_o            = berr_q || beat_bad;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q   <= ST_IDLE;
      valid_q   <= '0;
      araddr_q  <= '0;
      arvalid_q <= 1'b0;
      beat_q    <= '0;
      berr_q    <= 1'b0;
      idx_l_q   <= '0;
      tag_l_q   <= '0;
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      araddr_q  <= araddr_d;
      arvalid_q <= arvalid_d;
      beat_q    <= beat_d;
      berr_q    <= berr_d;
      idx_l_q   <= idx_l_d;
      tag_l_q   <= tag_l_d;
    end
  end

`ifdef CACHE_AXI_FLUSH_EN
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) flush_pend_q <= 1'b0;
    else       flush_pend_q <= flush_pend_d;
  end
`endif

  // Tag and data storage carry no reset; the valid bits gate every use.
  always_ff @(posedge CLK) begin
    if (beat_we) data_mem[{idx_l_q, beat_q}] <= M_AXI_RDATA;
    if (tag_we)  tag_mem[idx_l_q] <= tag_l_q;
  end

  assign RVALID           = rvalid_o;
  assign RDATA            = rvalid_o ? data_mem[{r_idx, r_off}] : 32'h0;
  assign HIT_CHECK_RESULT = !RDEN || h_hit;
  assign ERR              = err_o;

  assign M_AXI_ARADDR  = araddr_q;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_ARLEN   = 8'(LINE_WORDS - 1);
  assign M_AXI_ARSIZE  = 3'b010;
  assign M_AXI_ARBURST = 2'b01;
  assign M_AXI_RREADY  = state_q == ST_READ;

  assign M_AXI_AWADDR  = 32'h0;
  assign M_AXI_AWLEN   = 8'h0;
  assign M_AXI_AWSIZE  = 3'b010;
  assign M_AXI_AWBURST = 2'b01;
  assign M_AXI_AWVALID = 1'b0;
  assign M_AXI_WDATA   = 32'h0;
  assign M_AXI_WSTRB   = 4'hF;
  assign M_AXI_WLAST   = 1'b0;
  assign M_AXI_WVALID  = 1'b0;
  assign M_AXI_BREADY  = 1'b0;

  logic unused_ok;
  assign unused_ok = ^{M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BRESP, M_AXI_BVALID,
                       RADDR[1:0], HIT_CHECK[OFF_W+1:0]};
endmodule

// File: tb/tb_cache_axi_lines.sv
// Directed bench for cache_axi_lines (LINES=64, LINE_WORDS=8) with a scripted AXI read slave.
module tb_cache_axi_lines;
  logic        clk, rstn;
  logic [31:0] hit_check;
  logic        hit_check_result;
  logic        rden;
  logic [31:0] raddr;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid, arready;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rlast, s_rvalid, rready;
  logic [31:0] awaddr, wdata;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid, wlast, wvalid, bready;
  logic [3:0]  wstrb;

  int checks = 0;
  int errors = 0;

  cache_axi_lines #(.LINES(64), .LINE_WORDS(8)) dut (
    .CLK(clk), .RSTN(rstn),
    .HIT_CHECK(hit_check), .HIT_CHECK_RESULT(hit_check_result),
    .RDEN(rden), .RADDR(raddr), .RVALID(rvalid), .RDATA(rdata), .ERR(err),
    .M_AXI_ARADDR(araddr), .M_AXI_ARLEN(arlen), .M_AXI_ARSIZE(arsize),
    .M_AXI_ARBURST(arburst), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(s_rdata), .M_AXI_RRESP(s_rresp), .M_AXI_RLAST(s_rlast),
    .M_AXI_RVALID(s_rvalid), .M_AXI_RREADY(rready),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWLEN(awlen), .M_AXI_AWSIZE(awsize),
    .M_AXI_AWBURST(awburst), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(1'b0),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WLAST(wlast),
    .M_AXI_WVALID(wvalid), .M_AXI_WREADY(1'b0),
    .M_AXI_BRESP(2'b00), .M_AXI_BVALID(1'b0), .M_AXI_BREADY(bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Serve one read burst: wait for AR, optionally stall ARREADY, then 8 beats.
  task automatic serve_burst(input logic [31:0] exp_addr, input logic [31:0] d0,
                             input int ar_delay, input int err_beat, input bit gaps);
    int cyc = 0;
    while (!arvalid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (arvalid !== 1'b1) begin
      errors++;
      $display("FAIL ar_wait arvalid got %b exp 1", arvalid);
      return;
    end
    checks++;
    if (araddr !== exp_addr) begin
      errors++;
      $display("FAIL araddr got %h exp %h", araddr, exp_addr);
    end
    checks++;
    if (arlen !== 8'd7 || arsize !== 3'b010 || arburst !== 2'b01) begin
      errors++;
      $display("FAIL ar_attr got %h/%b/%b exp 07/010/01", arlen, arsize, arburst);
    end
    for (int i = 0; i < ar_delay; i++) begin
      arready = 1'b0;
      @(negedge clk);
      checks++;
      if (arvalid !== 1'b1 || araddr !== exp_addr) begin
        errors++;
        $display("FAIL ar_stall cyc %0d got %b/%h exp 1/%h", i, arvalid, araddr, exp_addr);
      end
    end
    arready = 1'b1;
    @(negedge clk);
    arready = 1'b0;
    checks++;
    if (rready !== 1'b1 || arvalid !== 1'b0) begin
      errors++;
      $display("FAIL read_enter rready/arvalid got %b/%b exp 1/0", rready, arvalid);
    end
    for (int b = 0; b < 8; b++) begin
      if (gaps && (b % 2 == 1)) begin
        s_rvalid = 1'b0;
        @(negedge clk);
      end
      s_rvalid = 1'b1;
      s_rdata  = d0 + 32'(b);
      s_rresp  = (b == err_beat) ? 2'b10 : 2'b00;
      s_rlast  = (b == 7);
      #1;
      checks++;
      if (err !== ((b == 7) && (err_beat >= 0))) begin
        errors++;
        $display("FAIL err beat %0d got %b exp %b", b, err, (b == 7) && (err_beat >= 0));
      end
      @(negedge clk);
      s_rvalid = 1'b0;
      s_rlast  = 1'b0;
      s_rresp  = 2'b00;
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; rden = 1'b0; raddr = 32'h0; hit_check = 32'h1020;
    arready = 1'b0; s_rvalid = 1'b0; s_rlast = 1'b0; s_rresp = 2'b00; s_rdata = 32'h0;
    repeat (2) @(negedge clk);
    checks++;
    if (arvalid !== 1'b0 || araddr !== 32'h0) begin
      errors++;
      $display("FAIL reset_ar got %b/%h exp 0/00000000", arvalid, araddr);
    end
    checks++;
    if (rvalid !== 1'b0 || rready !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_out got %b%b%b exp 000", rvalid, rready, err);
    end
    checks++;
    if (hit_check_result !== 1'b1) begin
      errors++;
      $display("FAIL reset_hcr got %b exp 1", hit_check_result);
    end
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_cold();
    rden = 1'b1; raddr = 32'h0000_1024; hit_check = 32'h0000_1024;
    #1;
    checks++;
    if (rvalid !== 1'b0 || hit_check_result !== 1'b0) begin
      errors++;
      $display("FAIL cold_miss rvalid/hcr got %b/%b exp 0/0", rvalid, hit_check_result);
    end
    serve_burst(32'h0000_1020, 32'hA0, 0, -1, 1'b0);
    #1;
    checks++;
    if (rvalid !== 1'b1 || rdata !== 32'hA1) begin
      errors++;
      $display("FAIL cold_fill got %b/%h exp 1/000000a1", rvalid, rdata);
    end
  endtask

  task automatic test_hit();
    raddr = 32'h0000_103C; hit_check = 32'h0000_1820;
    #1;
    checks++;
    if (rvalid !== 1'b1 || rdata !== 32'hA7) begin
      errors++;
      $display("FAIL hit got %b/%h exp 1/000000a7", rvalid, rdata);
    end
    checks++;
    if (hit_check_result !== 1'b0) begin
      errors++;
      $display("FAIL hcr_conflict got %b exp 0", hit_check_result);
    end
    @(negedge clk);
    checks++;
    if (arvalid !== 1'b0) begin
      errors++;
      $display("FAIL hit_no_ar got %b exp 0", arvalid);
    end
    rden = 1'b0;
    #1;
    checks++;
    if (hit_check_result !== 1'b1 || rvalid !== 1'b0) begin
      errors++;
      $display("FAIL idle_probe hcr/rvalid got %b/%b exp 1/0", hit_check_result, rvalid);
    end
  endtask

  task automatic test_conflict();
    rden = 1'b1; raddr = 32'h0000_1820; hit_check = 32'h0000_1820;
    #1;
    checks++;
    if (rvalid !== 1'b0 || hit_check_result !== 1'b0) begin
      errors++;
      $display("FAIL conflict_miss got %b/%b exp 0/0", rvalid, hit_check_result);
    end
    serve_burst(32'h0000_1820, 32'hB0, 0, -1, 1'b0);
    #1;
    checks++;
    if (rvalid !== 1'b1 || rdata !== 32'hB0) begin
      errors++;
      $display("FAIL conflict_fill got %b/%h exp 1/000000b0", rvalid, rdata);
    end
    raddr = 32'h0000_1020;
    #1;
    checks++;
    if (rvalid !== 1'b0) begin
      errors++;
      $display("FAIL evicted_miss got %b exp 0", rvalid);
    end
    serve_burst(32'h0000_1020, 32'hC0, 0, -1, 1'b0);
    #1;
    checks++;
    if (rvalid !== 1'b1 || rdata !== 32'hC0) begin
      errors++;
      $display("FAIL refill_back got %b/%h exp 1/000000c0", rvalid, rdata);
    end
  endtask

  task automatic test_error();
    raddr = 32'h0000_2040;
    serve_burst(32'h0000_2040, 32'h50, 0, 3, 1'b0);
    #1;
    checks++;
    if (rvalid !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL err_after got rvalid %b err %b exp 0/0", rvalid, err);
    end
    @(negedge clk);
    checks++;
    if (arvalid !== 1'b1 || araddr !== 32'h0000_2040) begin
      errors++;
      $display("FAIL err_retry got %b/%h exp 1/00002040", arvalid, araddr);
    end
    serve_burst(32'h0000_2040, 32'hD0, 0, -1, 1'b0);
    #1;
    checks++;
    if (rvalid !== 1'b1 || rdata !== 32'hD0) begin
      errors++;
      $display("FAIL err_recover got %b/%h exp 1/000000d0", rvalid, rdata);
    end
  endtask

  task automatic test_backpressure();
    raddr = 32'h0000_3064;
    serve_burst(32'h0000_3060, 32'hE0, 5, -1, 1'b1);
    #1;
    checks++;
    if (rvalid !== 1'b1 || rdata !== 32'hE1) begin
      errors++;
      $display("FAIL bp_word1 got %b/%h exp 1/000000e1", rvalid, rdata);
    end
    raddr = 32'h0000_307C;
    #1;
    checks++;
    if (rvalid !== 1'b1 || rdata !== 32'hE7) begin
      errors++;
      $display("FAIL bp_word7 got %b/%h exp 1/000000e7", rvalid, rdata);
    end
  endtask

  task automatic test_reset_mid();
    int cyc = 0;
    raddr = 32'h0000_1024;
    #1;
    checks++;
    if (rvalid !== 1'b1 || rdata !== 32'hC1) begin
      errors++;
      $display("FAIL pre_rst_hit got %b/%h exp 1/000000c1", rvalid, rdata);
    end
    raddr = 32'h0000_4080;
    while (!arvalid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (arvalid !== 1'b1) begin
      errors++;
      $display("FAIL mid_ar_wait got %b exp 1", arvalid);
    end
    arready = 1'b1;
    @(negedge clk);
    arready = 1'b0;
    // Seen from outside, every beat writes into the new line; RADDR changes here must not matter.
    raddr = 32'h0000_1820;
    for (int b = 0; b < 4; b++) begin
      s_rvalid = 1'b1; s_rdata = 32'h70 + 32'(b); s_rlast = 1'b0;
      @(negedge clk);
    end
    s_rvalid = 1'b0;
    checks++;
    if (rready !== 1'b1) begin
      errors++;
      $display("FAIL mid_in_read got %b exp 1", rready);
    end
    rden = 1'b0;
    rstn = 1'b0;
    #1;
    checks++;
    if (arvalid !== 1'b0 || rready !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst got arvalid %b rready %b exp 0/0", arvalid, rready);
    end
    @(negedge clk);
    rstn = 1'b1;
    rden = 1'b1; raddr = 32'h0000_1024; hit_check = 32'h0000_1024;
    #1;
    checks++;
    if (rvalid !== 1'b0 || hit_check_result !== 1'b0) begin
      errors++;
      $display("FAIL post_rst_miss got %b/%b exp 0/0", rvalid, hit_check_result);
    end
    rden = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_cold();
    test_hit();
    test_conflict();
    test_error();
    test_backpressure();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cache_axi_lines.md
CACHE_AXI_LINES -- requirements
Module: cache_axi_lines

Interface
REQ-001 SHALL have parameter LINES, default 64: number of direct-mapped lines, power of 2, 2..1024.
REQ-002 SHALL have parameter LINE_WORDS, default 8: 32-bit words per line = AXI burst length, power of 2, 2..256.
REQ-003 SHALL have port CLK  in  1  sole clock for the cache and AXI master.
REQ-004 SHALL have port RSTN  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports HIT_CHECK  in  32  probe address; HIT_CHECK_RESULT  out  1  probe result.
REQ-006 SHALL have ports RDEN  in  1  read request; RADDR  in  32  byte address, word-aligned.
REQ-007 SHALL have ports RVALID  out  1  read hit; RDATA  out  32  read data.
REQ-008 SHALL have port ERR  out  1  one-cycle pulse on a failed refill.
REQ-009 SHALL have AR outputs M_AXI_ARADDR 32, M_AXI_ARLEN 8, M_AXI_ARSIZE 3, M_AXI_ARBURST 2, M_AXI_ARVALID 1, and input M_AXI_ARREADY 1.
REQ-010 SHALL have R inputs M_AXI_RDATA 32, M_AXI_RRESP 2, M_AXI_RLAST 1, M_AXI_RVALID 1, and output M_AXI_RREADY 1.
REQ-011 SHALL have AW/W/B ports as in the existing cache: AW/W outputs tied inactive (AWVALID=WVALID=0, WSTRB=4'hF, AWSIZE=3'b010, AWBURST=2'b01, others 0), B inputs ignored.

Function
REQ-012 Address split SHALL be: OFF = RADDR[log2(LINE_WORDS)+1:2], IDX = next log2(LINES) bits, TAG = remaining upper bits.
REQ-013 Each line SHALL hold a valid bit, a TAG and LINE_WORDS data words.
REQ-014 A hit SHALL mean valid[IDX] and tag[IDX]==TAG, evaluated combinationally.
REQ-015 RVALID SHALL be RDEN && hit && state==IDLE, combinationally; RDATA SHALL be data[IDX][OFF] when RVALID, else 0.
REQ-016 HIT_CHECK_RESULT SHALL be !RDEN || HIT_CHECK hits per REQ-014, regardless of state.
REQ-017 FSM SHALL have states IDLE, ADDR, READ.
REQ-018 IDLE->ADDR SHALL occur on RDEN && !hit; the line-aligned address {TAG,IDX,0} SHALL be latched into M_AXI_ARADDR, and ARVALID SHALL rise the next cycle.
REQ-019 In ADDR, ARVALID SHALL be 1 and ARADDR held stable; ADDR->READ SHALL occur on the cycle ARVALID && ARREADY.
REQ-020 M_AXI_ARLEN SHALL be LINE_WORDS-1, ARSIZE 3'b010, ARBURST 2'b01 (INCR), constant.
REQ-021 M_AXI_RREADY SHALL be 1 exactly in READ.
REQ-022 Each RVALID&&RREADY beat SHALL write data[latched IDX][beat counter]; counter starts at 0 and is log2(LINE_WORDS) bits wide.
REQ-023 Any beat with RRESP!=2'b00 SHALL set a sticky error flag for the current burst.
REQ-024 On the RLAST beat, the FSM SHALL go READ->IDLE; with no error, valid[IDX] SHALL be set to 1 and tag[IDX] to the latched TAG.
REQ-025 On an errored burst, valid[IDX] SHALL be 0 and ERR SHALL pulse high for one cycle at the RLAST beat.
REQ-026 valid[IDX] SHALL be cleared on the IDLE->ADDR transition, so a partially written line never hits.
REQ-027 RADDR/RDEN changes during ADDR/READ SHALL NOT affect the burst in flight.
REQ-028 After a refill, the request SHALL be re-evaluated in IDLE; a hit gives RVALID at the earliest one cycle after RLAST.
REQ-029 Beats arriving before RLAST at counter wrap SHALL overwrite modulo LINE_WORDS; RVALID outside READ SHALL be ignored.

Reset
REQ-030 RSTN low SHALL asynchronously force state IDLE, all valid bits 0, ARVALID 0, ARADDR 0, burst counter 0, error flag 0 and ERR 0.
REQ-031 Reset mid-burst SHALL abandon the burst; the AXI slave is reset by the same RSTN. Tags and data SHALL NOT need reset.

Configuration
REQ-032 With CACHE_AXI_FLUSH_EN defined, an input FLUSH (1 bit) SHALL exist; FLUSH high in IDLE SHALL clear all valid bits in one cycle, with RVALID 0 that cycle.
REQ-033 With CACHE_AXI_FLUSH_EN defined, FLUSH asserted in ADDR/READ SHALL be held pending and applied in the first IDLE cycle, discarding the just-filled line.
REQ-034 Without CACHE_AXI_FLUSH_EN, the FLUSH port SHALL be absent and valid bits SHALL clear only by reset or refill.

Verification (LINES=64, LINE_WORDS=8)
REQ-035 Cold read: RDEN=1, RADDR=0x0000_1024 -> ARADDR=0x0000_1020, ARLEN=7, one 8-beat burst of 0xA0..0xA7 -> RVALID=1, RDATA=0xA1.
REQ-036 Hit: after REQ-035, RADDR=0x0000_103C -> RVALID=1, RDATA=0xA7 same cycle; no AR activity.
REQ-037 Conflict: RADDR=0x0000_1820 (same IDX 1, new TAG) -> HIT_CHECK_RESULT=0 for HIT_CHECK=0x1820, refill; then RADDR=0x1020 misses again.
REQ-038 Error: burst with RRESP=2'b10 on beat 3 -> ERR pulses once at RLAST, next cycle re-requests the same ARADDR.
REQ-039 Backpressure: ARREADY held 0 for 5 cycles -> ARVALID/ARADDR stable throughout; RVALID gaps inside the burst -> data correct.
REQ-040 Reset mid-READ after beat 4 -> ARVALID=0, state IDLE, previous hit address now misses.
